gerador_de_pulsos_botoes: RTL

Debounces the two raw active-low pushbuttons that drive the RPN calculator. It turns each confirmed press into a single-cycle `enter_pulso` or `executar_pulso` for the control unit that sequences registers A, B and Resultado. The block sits between the board keys and the control unit's pulse inputs, and is the only source of those pulses. Its outputs are registered, so the control unit can use them directly.

---
 rtl/gerador_de_pulsos_botoes.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/gerador_de_pulsos_botoes.sv
// Debounces the ENTER and EXECUTAR keys (active-low, asynchronous) into registered one-cycle pulses.
// Define BLOQUEIO_MUTUO_EN to make the two channels mutually exclusive.
module gerador_de_pulsos_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic botao_enter_n,
  input  logic botao_executar_n,
  output logic enter_pulso,
  output logic executar_pulso,
  output logic botao_ocupado
);

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_P      = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_S      = 2'd3
  } estado_t;

  // Channel 0 is ENTER, channel 1 is EXECUTAR.
  localparam int CANAIS = 2;
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_UM     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CICLOS - 32'd1);

  logic [1:0]       sinc_a_r;
  logic [1:0]       sinc_b_r;
  logic [1:0]       pressionado_s;
  estado_t          estado_r       [CANAIS];
  estado_t          estado_bruto_s [CANAIS];
  estado_t          estado_s       [CANAIS];
  logic [CNT_W-1:0] cont_r         [CANAIS];
  logic [CNT_W-1:0] cont_bruto_s   [CANAIS];
  logic [CNT_W-1:0] cont_s         [CANAIS];
  logic [1:0]       aceite_bruto_s;
  logic [1:0]       aceite_s;
  logic             pendente_r;
  logic             enter_pulso_r;
  logic             executar_pulso_r;
  logic             botao_ocupado_r;

  // Two-flop synchronizers, reset to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sinc_a_r <= 2'b11;
      sinc_b_r <= 2'b11;
    end else begin
      sinc_a_r <= {botao_executar_n, botao_enter_n};
      sinc_b_r <= sinc_a_r;
    end
  end

`ifdef BLOQUEIO_MUTUO_EN
  logic [1:0] espera_r;
  logic [1:0] espera_s;
  logic [1:0] bloqueio_s;

  // A key held during a lock stays ignored until it is seen released.
  always_comb begin
    pressionado_s = ~sinc_b_r & ~espera_r;
  end
`else
  // Independent channels: the synchronized level drives the FSM directly.
  always_comb begin
    pressionado_s = ~sinc_b_r;
  end
`endif

  // Per-channel debounce FSM next state and counter.
  always_comb begin
    for (int i = 0; i < CANAIS; i++) begin
      estado_bruto_s[i] = estado_r[i];
      cont_bruto_s[i]   = cont_r[i];
      aceite_bruto_s[i] = 1'b0;
      case (estado_r[i])
        SOLTO: begin
          if (pressionado_s[i]) begin
            estado_bruto_s[i] = CONF_P;
            cont_bruto_s[i]   = CNT_UM;
          end else begin
            cont_bruto_s[i]   = CNT_ZERO;
          end
        end
        CONF_P: begin
          if (!pressionado_s[i]) begin
            estado_bruto_s[i] = SOLTO;
            cont_bruto_s[i]   = CNT_ZERO;
          end else if (cont_r[i] >= CNT_ULTIMO) begin
            estado_bruto_s[i] = PRESSIONADO;
            cont_bruto_s[i]   = CNT_ZERO;
            aceite_bruto_s[i] = 1'b1;
          end else begin
            cont_bruto_s[i]   = cont_r[i] + CNT_UM;
          end
        end
        PRESSIONADO: begin
          if (!pressionado_s[i]) begin
            estado_bruto_s[i] = CONF_S;
            cont_bruto_s[i]   = CNT_UM;
          end else begin
            cont_bruto_s[i]   = CNT_ZERO;
          end
        end
        CONF_S: begin
          if (pressionado_s[i]) begin
            estado_bruto_s[i] = PRESSIONADO;
            cont_bruto_s[i]   = CNT_ZERO;
          end else if (cont_r[i] >= CNT_ULTIMO) begin
            estado_bruto_s[i] = SOLTO;
            cont_bruto_s[i]   = CNT_ZERO;
          end else begin
            cont_bruto_s[i]   = cont_r[i] + CNT_UM;
          end
        end
        default: begin
          estado_bruto_s[i] = SOLTO;
          cont_bruto_s[i]   = CNT_ZERO;
        end
      endcase
    end
  end

`ifdef BLOQUEIO_MUTUO_EN
  // ENTER has priority: its acceptance on this edge already locks EXECUTAR out.
  always_comb begin
    bloqueio_s[0] = (estado_r[1] == PRESSIONADO) || (estado_r[1] == CONF_S);
    bloqueio_s[1] = (estado_r[0] == PRESSIONADO) || (estado_r[0] == CONF_S) || aceite_bruto_s[0];
    for (int i = 0; i < CANAIS; i++) begin
      if (bloqueio_s[i]) begin
        estado_s[i] = SOLTO;
        cont_s[i]   = CNT_ZERO;
        aceite_s[i] = 1'b0;
      end else begin
        estado_s[i] = estado_bruto_s[i];
        cont_s[i]   = cont_bruto_s[i];
        aceite_s[i] = aceite_bruto_s[i];
      end
    end
    espera_s = ~sinc_b_r & (bloqueio_s | espera_r);
  end

  // Release-required flags for channels that were locked while pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      espera_r <= 2'b00;
    end else begin
      espera_r <= espera_s;
    end
  end
`else
  // Without the lock the channel results pass through unchanged.
  always_comb begin
    for (int i = 0; i < CANAIS; i++) begin
      estado_s[i] = estado_bruto_s[i];
      cont_s[i]   = cont_bruto_s[i];
      aceite_s[i] = aceite_bruto_s[i];
    end
  end
`endif

  // Channel state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CANAIS; i++) begin
        estado_r[i] <= SOLTO;
        cont_r[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < CANAIS; i++) begin
        estado_r[i] <= estado_s[i];
        cont_r[i]   <= cont_s[i];
      end
    end
  end

  // Pulse outputs; a same-edge EXECUTAR acceptance is deferred one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pendente_r       <= 1'b0;
      enter_pulso_r    <= 1'b0;
      executar_pulso_r <= 1'b0;
      botao_ocupado_r  <= 1'b0;
    end else begin
      pendente_r       <= aceite_s[1] & aceite_s[0];
      enter_pulso_r    <= aceite_s[0];
      executar_pulso_r <= pendente_r | (aceite_s[1] & ~aceite_s[0]);
      botao_ocupado_r  <= (estado_s[0] != SOLTO) || (estado_s[1] != SOLTO);
    end
  end

  assign enter_pulso    = enter_pulso_r;
  assign executar_pulso = executar_pulso_r;
  assign botao_ocupado  = botao_ocupado_r;

endmodule
